uart_tx_cfg: RTL

Parametrised UART transmitter with an input FIFO, replacing the fixed 8-bit, edge-triggered transmitter used on the board-level serial links. Frame format, baud rate, bit order and buffering depth are set by parameters. A valid/ready handshake replaces the enable-edge trigger, so a producer can queue several words and the block sends them back-to-back. The block sits between any byte/word producer (protocol engine, debug dumper) and the `tx` pad.

---
 rtl/uart_tx_cfg.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with an input FIFO.
// Frame = start(0), DATA_BITS data bits (LSB or MSB first), optional parity,
// STOP_BITS stop bits(1). Words queue in a power-of-two FIFO and leave back-to-back.
//
// Handshake: a word is transferred on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready depends only on registered state (FIFO not
// full). The producer may change or drop tx_valid at any time, and tx_data is
// ignored whenever the transfer condition is not met.
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BCW      = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    // Wide enough for the largest legal data-bit index (8).
    localparam int BITW     = 4;

    // Reject configurations the datapath cannot represent.
    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;
    logic                 fifo_nonempty;

    assign tx_ready      = (fifo_count != CW'(FIFO_DEPTH));
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign head          = mem[rd_ptr];

    // Storage array: written on every accepted word, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t               state;
    logic [BCW-1:0]       baud_cnt;
    logic [BITW-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 baud_last;
    logic                 data_last;
    logic                 stop_last;
    logic                 head_par;
    logic                 line;

    assign baud_last = (baud_cnt == BCW'(BAUD_DIV - 1));
    assign data_last = (bit_cnt == BITW'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == BITW'(STOP_BITS - 1));
    // Even parity is the XOR of the data; odd parity is its complement.
    assign head_par  = (^head) ^ (PARITY == 1);
    // A word leaves the FIFO when idle, or on the very last stop cycle so the
    // next start bit follows without a gap.
    assign pop = fifo_nonempty &&
                 ((state == S_IDLE) || (state == S_STOP && baud_last && stop_last));

    // Line level implied by the current state; registered into tx one cycle later.
    always_comb begin
        line = 1'b1;
        case (state)
            S_START:  line = 1'b0;
            S_DATA:   line = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];
            S_PARITY: line = par_bit;
            default:  line = 1'b1;
        endcase
    end

    // Frame FSM with registered tx, busy and tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx      <= line;
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg    <= head;
                        par_bit  <= head_par;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (MSB_FIRST != 0) begin
                            shreg <= {shreg[DATA_BITS-2:0], 1'b0};
                        end else begin
                            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                        end
                        if (data_last) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            tx_done <= 1'b1;
                            bit_cnt <= '0;
                            if (pop) begin
                                shreg   <= head;
                                par_bit <= head_par;
                                state   <= S_START;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
